// File: rtl/npu_pkg.sv
// npu_pkg: shared activation type and feeder state encoding for the NPU datapath.
package npu_pkg;
    localparam int DATA_W = 16;
    typedef logic signed [DATA_W-1:0] act_t;
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} feed_state_t;
endpackage

// File: rtl/act_fifo.sv
// act_fifo: synchronous vector FIFO with no write-to-read bypass.
// A word pushed at one edge becomes poppable in the following cycle.
module act_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign rd_data = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end
    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/iact_skew_feeder.sv
// iact_skew_feeder: buffers activation vectors and streams tiles into the PE rows,
// delaying lane i by i cycles to form the systolic diagonal wavefront.
module iact_skew_feeder #(
    parameter int N      = 4,
    parameter int DATA_W = npu_pkg::DATA_W,
    parameter int DEPTH  = 16,
    parameter int LEN_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [N*DATA_W-1:0] s_data,
    input  logic                start,
    input  logic [LEN_W-1:0]    len,
    output logic                busy,
    output logic                done,
    output logic [N*DATA_W-1:0] iact_out,
    output logic [N-1:0]        iact_vld
);
    import npu_pkg::*;
    localparam int CW = $clog2(N);
    feed_state_t state;
    logic [LEN_W-1:0] len_q, popped;
    logic [CW-1:0] drain_cnt;
    logic full, empty, pop;
    logic [N*DATA_W-1:0] head;
    assign pop = (state == STREAM) && !empty;
    assign s_ready = !full;
    assign busy = state != IDLE;
    act_fifo #(.W(N*DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(s_valid),
        .wr_data(s_data),
        .pop(pop),
        .rd_data(head),
        .full(full),
        .empty(empty)
    );
    // DRAIN lasts N-1 cycles, so done rises together with lane N-1's final element.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            len_q <= '0;
            popped <= '0;
            drain_cnt <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (len != '0) begin
                        len_q <= len;
                        popped <= '0;
                        state <= STREAM;
                    end else done <= 1'b1;
                end
                STREAM: if (pop) begin
                    popped <= popped + LEN_W'(1);
                    if (popped + LEN_W'(1) == len_q) begin
                        state <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + CW'(1);
                    if (drain_cnt == CW'(N-2)) begin
                        state <= IDLE;
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    // Empty cycles load a zero bubble so every lane sees the same gap pattern.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic signed [DATA_W-1:0] d [i+1];
        logic [i:0] v;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                v <= '0;
                for (int j = 0; j <= i; j++) d[j] <= '0;
            end else begin
                v[0] <= pop;
                d[0] <= pop ? head[i*DATA_W +: DATA_W] : '0;
                for (int j = 1; j <= i; j++) begin
                    v[j] <= v[j-1];
                    d[j] <= d[j-1];
                end
            end
        end
        assign iact_vld[i] = v[i];
        assign iact_out[i*DATA_W +: DATA_W] = v[i] ? d[i] : '0;
    end
endmodule
